// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the round-robin ALU front-end.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SEL_W   = 4;

  // Requester index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr_i, wrapping modulo N.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: accept, one EXEC
// cycle with registered operands, then hold the captured result until taken.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      rsp_carry,
  output logic [DATA_W-1:0]         A,
  output logic [DATA_W-1:0]         B,
  output logic [SEL_W-1:0]          ALU_Sel,
  input  logic [DATA_W-1:0]         ALU_Out,
  input  logic                      CarryOut,
  output logic                      busy
);

  localparam int IW = idx_w(NUM_REQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gidx_q;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic [SEL_W-1:0]  sel_q;
  logic              carry_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               any;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  assign accept = (state_q == IDLE) && any;
  assign ptr_d  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[gidx_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? gnt : '0;
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gidx_q] = 1'b1;
    busy      = (state_q != IDLE);
  end

  // Operands only move on accept so the ALU inputs are quiet otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q  <= ptr_d;
        gidx_q <= gidx;
        a_q    <= req_a[gidx*DATA_W +: DATA_W];
        b_q    <= req_b[gidx*DATA_W +: DATA_W];
        sel_q  <= req_sel[gidx*SEL_W +: SEL_W];
      end
      if (state_q == EXEC) begin
        out_q   <= ALU_Out;
        carry_q <= CarryOut;
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign rsp_out   = out_q;
  assign rsp_carry = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on its outputs.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [7:0]  rsp_out, a_o, b_o, alu_out;
  logic [3:0]  alu_sel;
  logic        rsp_carry, carry_out, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .A         (a_o),
    .B         (b_o),
    .ALU_Sel   (alu_sel),
    .ALU_Out   (alu_out),
    .CarryOut  (carry_out),
    .busy      (busy)
  );

  // 0 add (with carry), 1 sub, 2 and, 3 or, 4 xor
  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (alu_sel)
      4'h0: {carry_out, alu_out} = {1'b0, a_o} + {1'b0, b_o};
      4'h1: alu_out = a_o - b_o;
      4'h2: alu_out = a_o & b_o;
      4'h3: alu_out = a_o | b_o;
      4'h4: alu_out = a_o ^ b_o;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] s0, s1;
    logic [1:0] ready;
    logic [7:0] out;
    logic       carry;
  } vec_t;

  vec_t tv[7];

  initial begin
    logic [7:0] ea, eb;
    logic [3:0] es;
    logic [1:0] exp_v[4];
    logic [7:0] exp_o[4];
    int waited;

    // valid, a0, b0, a1, b1, s0, s1, ready, out, carry  (rr_ptr tracked by hand)
    tv[0] = '{2'b01, 8'hF0, 8'h20, 8'h5A, 8'h5A, 4'h0, 4'h0, 2'b01, 8'h10, 1'b1};
    tv[1] = '{2'b01, 8'h05, 8'h03, 8'h5A, 8'h5A, 4'h1, 4'h0, 2'b01, 8'h02, 1'b0};
    tv[2] = '{2'b10, 8'h5A, 8'h5A, 8'h0F, 8'hF0, 4'h0, 4'h2, 2'b10, 8'h00, 1'b0};
    tv[3] = '{2'b11, 8'hAA, 8'h0F, 8'h11, 8'h22, 4'h3, 4'h0, 2'b01, 8'hAF, 1'b0};
    tv[4] = '{2'b11, 8'h11, 8'h22, 8'hFF, 8'h01, 4'h0, 4'h0, 2'b10, 8'h00, 1'b1};
    tv[5] = '{2'b10, 8'h5A, 8'h5A, 8'h3C, 8'hFF, 4'h0, 4'h4, 2'b10, 8'hC3, 1'b0};
    tv[6] = '{2'b11, 8'h80, 8'h80, 8'h12, 8'h12, 4'h0, 4'h0, 2'b01, 8'h00, 1'b1};

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_sel = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_A", a_o, 0);
    chk("rst_B", b_o, 0);
    chk("rst_sel", alu_sel, 0);
    chk("rst_out", {rsp_carry, rsp_out}, 0);
    rst_n = 1'b1;

    // contention: both held, alternating grants from requester 0
    @(negedge clk);
    req_a = {8'h10, 8'h01}; req_b = {8'h20, 8'h02}; req_sel = 8'h00;
    req_valid = 2'b11; rsp_ready = 2'b11;
    exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_o = '{8'h03, 8'h30, 8'h03, 8'h30};
    #1;
    chk("cont_first_ready", req_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (rsp_valid == 2'b00 && waited < 6) begin
        @(negedge clk); #1; waited++;
      end
      chk($sformatf("cont%0d_latency", k), waited, 2);
      chk($sformatf("cont%0d_rsp_valid", k), rsp_valid, exp_v[k]);
      chk($sformatf("cont%0d_rsp_out", k), rsp_out, exp_o[k]);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk); #1;
    end
    chk("cont_end_busy", busy, 0);

    // single-operation vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = tv[i].valid;
      req_a = {tv[i].a1, tv[i].a0}; req_b = {tv[i].b1, tv[i].b0}; req_sel = {tv[i].s1, tv[i].s0};
      rsp_ready = 2'b11;
      ea = tv[i].ready[0] ? tv[i].a0 : tv[i].a1;
      eb = tv[i].ready[0] ? tv[i].b0 : tv[i].b1;
      es = tv[i].ready[0] ? tv[i].s0 : tv[i].s1;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, tv[i].ready);
      @(negedge clk); #1;
      chk($sformatf("v%0d_exec_busy", i), busy, 1);
      chk($sformatf("v%0d_exec_ready", i), req_ready, 0);
      chk($sformatf("v%0d_exec_rsp_valid", i), rsp_valid, 0);
      chk($sformatf("v%0d_A", i), a_o, ea);
      chk($sformatf("v%0d_B", i), b_o, eb);
      chk($sformatf("v%0d_sel", i), alu_sel, es);
      req_valid = 2'b00; req_a = ~req_a; req_b = ~req_b;
      @(negedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tv[i].ready);
      chk($sformatf("v%0d_rsp_out", i), rsp_out, tv[i].out);
      chk($sformatf("v%0d_rsp_carry", i), rsp_carry, tv[i].carry);
      chk($sformatf("v%0d_A_hold", i), a_o, ea);
      @(negedge clk); #1;
      chk($sformatf("v%0d_done_valid", i), rsp_valid, 0);
      chk($sformatf("v%0d_done_busy", i), busy, 0);
    end

    // backpressure, with rsp_ready on the other requester ignored
    @(negedge clk);
    req_valid = 2'b01; req_a = {8'hEE, 8'h12}; req_b = {8'hEE, 8'h34}; req_sel = 8'h00;
    rsp_ready = 2'b10;
    #1;
    chk("bp_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 2'b01);
      chk($sformatf("bp%0d_rsp_out", i), rsp_out, 8'h46);
      chk($sformatf("bp%0d_req_ready", i), req_ready, 0);
      chk($sformatf("bp%0d_busy", i), busy, 1);
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    #1;
    chk("bp_release_valid", rsp_valid, 2'b01);
    @(negedge clk); #1;
    chk("bp_one_cycle", rsp_valid, 0);
    chk("bp_idle", busy, 0);
    @(negedge clk); #1;
    chk("bp_no_repeat", rsp_valid, 0);
    rsp_ready = 2'b00;

    // idle: wiggling request operands must not reach the ALU
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 8'($urandom);
      #1;
      chk($sformatf("idle%0d_busy", i), busy, 0);
      chk($sformatf("idle%0d_ready", i), req_ready, 0);
      chk($sformatf("idle%0d_ABsel", i), {alu_sel, a_o, b_o}, {4'h0, 8'h12, 8'h34});
    end

    // reset while in EXEC; rr_ptr is 1 beforehand
    @(negedge clk);
    req_valid = 2'b01; req_a = {8'h00, 8'h77}; req_b = {8'h00, 8'h11}; req_sel = 8'h00;
    rsp_ready = 2'b11;
    #1;
    chk("rx_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rx_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rx_busy", busy, 0);
    chk("rx_ABsel", {alu_sel, a_o, b_o}, 0);
    chk("rx_rsp", {rsp_valid, rsp_carry, rsp_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rx%0d_no_rsp", i), {busy, rsp_valid}, 0);
    end
    req_valid = 2'b11;
    #1;
    chk("rx_regrant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
